// File: rtl/otter_mmio_timer.sv
// ---------------------------------------------------------------------------
// otter_mmio_timer
//   Memory-mapped machine timer (mtime / mtimecmp) on the Otter external IO
//   bus. It decodes a 256-byte window at BASE_ADDR, provides registered read
//   data, and drives the machine-timer interrupt pending bit (MTIP) on
//   interrupt vector bit 7.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-low reset
//   i_iobus_re     read strobe (one cycle per access)
//   i_iobus_we     write strobe (one cycle per access)
//   i_iobus_sel    byte enables for writes
//   i_iobus_addr   byte address
//   i_iobus_wdata  write data
//   o_iobus_rdata  registered read data, valid the cycle after re
//   o_intrpt       interrupt vector, bit 7 = MTIP
//
// Register map (offset from BASE_ADDR)
//   0x00 MTIME_LO   0x04 MTIME_HI   0x08 MTIMECMP_LO   0x0C MTIMECMP_HI
//   0x10 CTRL  (bit0 EN, bits[15:8] PRESC)   0x14 STATUS (bit0 MTIP, RO)
// ---------------------------------------------------------------------------
module otter_mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0000,
    parameter logic [31:0] RESET_CTRL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_iobus_re,
    input  logic        i_iobus_we,
    input  logic [3:0]  i_iobus_sel,
    input  logic [31:0] i_iobus_addr,
    input  logic [31:0] i_iobus_wdata,
    output logic [31:0] o_iobus_rdata,
    output logic [31:0] o_intrpt
);

    localparam logic [5:0] REG_MTIME_LO = 6'd0;
    localparam logic [5:0] REG_MTIME_HI = 6'd1;
    localparam logic [5:0] REG_CMP_LO   = 6'd2;
    localparam logic [5:0] REG_CMP_HI   = 6'd3;
    localparam logic [5:0] REG_CTRL     = 6'd4;
    localparam logic [5:0] REG_STATUS   = 6'd5;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic        mtip_q, mtip_d;
    logic [31:0] rdata_q, rdata_d;

    logic        hit;
    logic [5:0]  reg_idx;
    logic [31:0] wmask;
    logic        wr_any;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
    logic        tick;
    logic [31:0] rd_val;
    logic [31:0] ctrl_val;
    logic [31:0] ctrl_merged;

    // Byte address bits select within a word only; the window ignores them.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_iobus_addr[1:0];

    assign hit     = (i_iobus_addr[31:8] == BASE_ADDR[31:8]);
    assign reg_idx = i_iobus_addr[7:2];

    // Expand byte enables into a bit mask for read-modify-write merging.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{i_iobus_sel[gi]}};
        end
    endgenerate

    // A write with no byte enables set is a no-op everywhere, including
    // the prescaler clear on CTRL.
    assign wr_any      = hit && i_iobus_we && (i_iobus_sel != 4'b0000);
    assign wr_mtime_lo = wr_any && (reg_idx == REG_MTIME_LO);
    assign wr_mtime_hi = wr_any && (reg_idx == REG_MTIME_HI);
    assign wr_cmp_lo   = wr_any && (reg_idx == REG_CMP_LO);
    assign wr_cmp_hi   = wr_any && (reg_idx == REG_CMP_HI);
    assign wr_ctrl     = wr_any && (reg_idx == REG_CTRL);

    assign ctrl_val    = {16'b0, presc_q, 7'b0, en_q};
    assign ctrl_merged = (ctrl_val & ~wmask) | (i_iobus_wdata & wmask);

    assign tick = en_q && (pcnt_q == presc_q);

    // Read mux over pre-edge register values.
    always_comb begin
        rd_val = 32'b0;
        if (hit) begin
            case (reg_idx)
                REG_MTIME_LO: rd_val = mtime_q[31:0];
                REG_MTIME_HI: rd_val = mtime_q[63:32];
                REG_CMP_LO:   rd_val = mtimecmp_q[31:0];
                REG_CMP_HI:   rd_val = mtimecmp_q[63:32];
                REG_CTRL:     rd_val = ctrl_val;
                REG_STATUS:   rd_val = {31'b0, mtip_q};
                default:      rd_val = 32'b0;
            endcase
        end
    end

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        presc_d    = presc_q;
        pcnt_d     = pcnt_q;
        rdata_d    = rdata_q;
        mtip_d     = (mtime_q >= mtimecmp_q);

        if (i_iobus_re) begin
            rdata_d = rd_val;
        end

        // A software write to either mtime half suppresses the increment
        // for the whole counter that cycle: the written half takes the new
        // value and the other half holds without carry.
        if (wr_mtime_lo || wr_mtime_hi) begin
            if (wr_mtime_lo) begin
                mtime_d[31:0] = (mtime_q[31:0] & ~wmask) | (i_iobus_wdata & wmask);
            end
            if (wr_mtime_hi) begin
                mtime_d[63:32] = (mtime_q[63:32] & ~wmask) | (i_iobus_wdata & wmask);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = (mtimecmp_q[31:0] & ~wmask) | (i_iobus_wdata & wmask);
        end
        if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wmask) | (i_iobus_wdata & wmask);
        end

        if (wr_ctrl) begin
            en_d    = ctrl_merged[0];
            presc_d = ctrl_merged[15:8];
            pcnt_d  = 8'd0;
        end else if (en_q) begin
            pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q       <= RESET_CTRL[0];
            presc_q    <= RESET_CTRL[15:8];
            pcnt_q     <= 8'd0;
            mtip_q     <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            mtip_q     <= mtip_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_iobus_rdata = rdata_q;
    assign o_intrpt      = {24'b0, mtip_q, 7'b0};

endmodule
